// File: rtl/dma_sim_pkg.sv
// Shared definitions for the dual-channel S2MM DMA write engine:
// fixed widths, register offsets, channel state encoding, the buffered
// beat payload and the register-write decode helper.
package dma_sim_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned ADDR_WIDTH     = 32;
  localparam int unsigned LEN_WIDTH      = 26;
  localparam int unsigned BYTES_PER_BEAT = 4;
  localparam int unsigned IOC_CLR_BIT    = 12;

  localparam logic [ADDR_WIDTH-1:0] OFF_DMACR  = 32'h0000_0030;
  localparam logic [ADDR_WIDTH-1:0] OFF_DMASR  = 32'h0000_0034;
  localparam logic [ADDR_WIDTH-1:0] OFF_DA     = 32'h0000_0048;
  localparam logic [ADDR_WIDTH-1:0] OFF_LENGTH = 32'h0000_0058;

  // Channel state encoding
  typedef logic [1:0] chan_state_t;
  localparam chan_state_t ST_HALT = 2'd0;
  localparam chan_state_t ST_IDLE = 2'd1;
  localparam chan_state_t ST_BUSY = 2'd2;

  // One buffered stream beat, already bound to its destination address
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } mem_beat_t;

  // Decoded per-channel register write strobes
  typedef struct packed {
    logic cr;
    logic sr;
    logic da;
    logic len;
  } reg_sel_t;

  // Match a register write against one channel's register window
  function automatic reg_sel_t decode_reg(input logic                  wvalid,
                                          input logic [ADDR_WIDTH-1:0] addr,
                                          input logic [ADDR_WIDTH-1:0] base);
    reg_sel_t sel;
    sel.cr  = wvalid && (addr == ADDR_WIDTH'(base + OFF_DMACR));
    sel.sr  = wvalid && (addr == ADDR_WIDTH'(base + OFF_DMASR));
    sel.da  = wvalid && (addr == ADDR_WIDTH'(base + OFF_DA));
    sel.len = wvalid && (addr == ADDR_WIDTH'(base + OFF_LENGTH));
    return sel;
  endfunction

endpackage

// File: rtl/dma_s2mm_channel.sv
// One S2MM channel: control registers, HALT/IDLE/BUSY state machine,
// address/length counters and a one-entry beat buffer.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   sel, wdata        decoded register write strobes and write data
//   tdata/tvalid/tlast/tready_c  AXI4-Stream slave (tready is combinational)
//   buf_full, buf_beat  buffered beat offered to the arbiter
//   buf_pop           arbiter handshake frees the buffer
//   done, halted      sticky completion flag, halted status
module dma_s2mm_channel
  import dma_sim_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  reg_sel_t              sel,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] tdata,
  input  logic                  tvalid,
  input  logic                  tlast,
  output logic                  tready_c,
  output logic                  buf_full,
  output mem_beat_t             buf_beat,
  input  logic                  buf_pop,
  output logic                  done,
  output logic                  halted
);

  chan_state_t           state_q;
  chan_state_t           state_d;
  logic                  rs;
  logic [ADDR_WIDTH-1:0] da;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [LEN_WIDTH-1:0]  len_bytes_c;
  logic                  start_c;
  logic                  finish_c;
  logic                  accept_c;

  // Byte count rounded down to whole beats
  assign len_bytes_c = wdata[LEN_WIDTH-1:0] & ~LEN_WIDTH'(BYTES_PER_BEAT - 1);

  // remaining is forced to zero by tlast, so it doubles as the "stop accepting" flag
  assign tready_c = (state_q == ST_BUSY) && rs && (remaining != '0) && !buf_full;
  assign accept_c = tvalid && tready_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HALT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; a transfer closes only once the buffered beat has drained
  always_comb begin
    state_d  = state_q;
    start_c  = 1'b0;
    finish_c = 1'b0;
    case (state_q)
      ST_HALT: if (rs) state_d = ST_IDLE;
      ST_IDLE: if (!rs) state_d = ST_HALT;
      ST_BUSY: begin
        if (!buf_full && ((remaining == '0) || !rs)) begin
          finish_c = 1'b1;
          state_d  = rs ? ST_IDLE : ST_HALT;
        end
      end
      default: state_d = ST_HALT;
    endcase
    if ((state_q != ST_BUSY) && rs && sel.len && (len_bytes_c != '0)) begin
      start_c = 1'b1;
      state_d = ST_BUSY;
    end
  end

  // Registers, counters, buffer and status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs        <= 1'b0;
      da        <= '0;
      ptr       <= '0;
      remaining <= '0;
      buf_full  <= 1'b0;
      buf_beat  <= '0;
      done      <= 1'b0;
      halted    <= 1'b1;
    end else begin
      halted <= (state_d == ST_HALT);

      if (sel.cr) rs <= wdata[0];
      if (sel.da) da <= {wdata[ADDR_WIDTH-1:2], 2'b00};

      if (start_c) begin
        remaining <= len_bytes_c;
        ptr       <= da;
      end else if (accept_c) begin
        ptr       <= ADDR_WIDTH'(ptr + ADDR_WIDTH'(BYTES_PER_BEAT));
        remaining <= tlast ? '0 : LEN_WIDTH'(remaining - LEN_WIDTH'(BYTES_PER_BEAT));
      end

      // accept only happens with an empty buffer, so it never races a pop
      if (accept_c) begin
        buf_full      <= 1'b1;
        buf_beat.addr <= ptr;
        buf_beat.data <= tdata;
      end else if (buf_pop) begin
        buf_full <= 1'b0;
      end

      // an RS-abort finishes without raising done
      if (finish_c && rs) begin
        done <= 1'b1;
      end else if (sel.sr && wdata[IOC_CLR_BIT]) begin
        done <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dma_sim_top.sv
// Dual-channel stream-to-memory DMA write engine. Decodes the shared
// register port into two channel windows and round-robin arbitrates the
// two channel buffers onto one memory write port.
// Ports:
//   aclk, areset                    clock, asynchronous active-high reset
//   reg_wvalid/reg_waddr/reg_wdata  register write port (always accepted)
//   s_axis_s2mm_1_*, s_axis_s2mm_2_*  stream inputs for channel 0 / 1
//   mem_wvalid/mem_wready/mem_waddr/mem_wdata/mem_wid  memory write port
//   done[1:0], halted[1:0]          per-channel status (bit0 = channel 0)
module dma_sim_top
  import dma_sim_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] DMA1_BASE = 32'h41E0_0000,
  parameter logic [ADDR_WIDTH-1:0] DMA2_BASE = 32'h41E1_0000
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  reg_wvalid,
  input  logic [ADDR_WIDTH-1:0] reg_waddr,
  input  logic [DATA_WIDTH-1:0] reg_wdata,
  input  logic [DATA_WIDTH-1:0] s_axis_s2mm_1_tdata,
  input  logic                  s_axis_s2mm_1_tvalid,
  input  logic                  s_axis_s2mm_1_tlast,
  output logic                  s_axis_s2mm_1_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_s2mm_2_tdata,
  input  logic                  s_axis_s2mm_2_tvalid,
  input  logic                  s_axis_s2mm_2_tlast,
  output logic                  s_axis_s2mm_2_tready,
  output logic                  mem_wvalid,
  input  logic                  mem_wready,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wid,
  output logic [1:0]            done,
  output logic [1:0]            halted
);

  reg_sel_t  sel0_c;
  reg_sel_t  sel1_c;
  mem_beat_t beat0;
  mem_beat_t beat1;
  logic [1:0] full;
  logic [1:0] pop_c;
  logic       grant_c;
  logic       handshake_c;
  logic       prio_q;
  logic       lock_q;
  logic       lock_id_q;

  // Register decode
  assign sel0_c = decode_reg(reg_wvalid, reg_waddr, DMA1_BASE);
  assign sel1_c = decode_reg(reg_wvalid, reg_waddr, DMA2_BASE);

  dma_s2mm_channel u_ch0 (
    .clk      (aclk),
    .rst      (areset),
    .sel      (sel0_c),
    .wdata    (reg_wdata),
    .tdata    (s_axis_s2mm_1_tdata),
    .tvalid   (s_axis_s2mm_1_tvalid),
    .tlast    (s_axis_s2mm_1_tlast),
    .tready_c (s_axis_s2mm_1_tready),
    .buf_full (full[0]),
    .buf_beat (beat0),
    .buf_pop  (pop_c[0]),
    .done     (done[0]),
    .halted   (halted[0])
  );

  dma_s2mm_channel u_ch1 (
    .clk      (aclk),
    .rst      (areset),
    .sel      (sel1_c),
    .wdata    (reg_wdata),
    .tdata    (s_axis_s2mm_2_tdata),
    .tvalid   (s_axis_s2mm_2_tvalid),
    .tlast    (s_axis_s2mm_2_tlast),
    .tready_c (s_axis_s2mm_2_tready),
    .buf_full (full[1]),
    .buf_beat (beat1),
    .buf_pop  (pop_c[1]),
    .done     (done[1]),
    .halted   (halted[1])
  );

  // Grant select; a stalled request stays locked so the port holds stable
  always_comb begin
    grant_c = prio_q;
    if (lock_q) begin
      grant_c = lock_id_q;
    end else if (full == 2'b01) begin
      grant_c = 1'b0;
    end else if (full == 2'b10) begin
      grant_c = 1'b1;
    end
  end

  // Memory port is a mux of the channel buffer flops
  assign mem_wvalid  = grant_c ? full[1] : full[0];
  assign mem_waddr   = grant_c ? beat1.addr : beat0.addr;
  assign mem_wdata   = grant_c ? beat1.data : beat0.data;
  assign mem_wid     = grant_c;
  assign handshake_c = mem_wvalid && mem_wready;
  assign pop_c       = {handshake_c && grant_c, handshake_c && !grant_c};

  // Round-robin priority and stall lock
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      prio_q    <= 1'b0;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
    end else begin
      if (handshake_c) prio_q <= !grant_c;
      lock_q    <= mem_wvalid && !mem_wready;
      lock_id_q <= grant_c;
    end
  end

endmodule

// File: tb/tb_dma_sim_top.sv
// Directed self-checking bench for dma_sim_top.
module tb_dma_sim_top;

  localparam logic [31:0] B0 = 32'h41E0_0000;
  localparam logic [31:0] B1 = 32'h41E1_0000;

  logic        aclk = 1'b0;
  logic        areset;
  logic        reg_wvalid;
  logic [31:0] reg_waddr;
  logic [31:0] reg_wdata;
  logic [1:0]  s_tvalid;
  logic [1:0]  s_tlast;
  logic [1:0]  s_tready;
  logic [31:0] s_tdata0;
  logic [31:0] s_tdata1;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_wid;
  logic [1:0]  done;
  logic [1:0]  halted;

  int total = 0;
  int bad   = 0;

  logic        rw_pend;
  logic [31:0] rw_addr;
  logic [31:0] rw_data;
  logic [1:0]  en;
  int          sent   [2];
  int          nbeats [2];
  int          last_at[2];
  logic [31:0] dbase  [2];

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic        log_wid [$];

  always #5 aclk = ~aclk;

  dma_sim_top dut (
    .aclk                 (aclk),
    .areset               (areset),
    .reg_wvalid           (reg_wvalid),
    .reg_waddr            (reg_waddr),
    .reg_wdata            (reg_wdata),
    .s_axis_s2mm_1_tdata  (s_tdata0),
    .s_axis_s2mm_1_tvalid (s_tvalid[0]),
    .s_axis_s2mm_1_tlast  (s_tlast[0]),
    .s_axis_s2mm_1_tready (s_tready[0]),
    .s_axis_s2mm_2_tdata  (s_tdata1),
    .s_axis_s2mm_2_tvalid (s_tvalid[1]),
    .s_axis_s2mm_2_tlast  (s_tlast[1]),
    .s_axis_s2mm_2_tready (s_tready[1]),
    .mem_wvalid           (mem_wvalid),
    .mem_wready           (mem_wready),
    .mem_waddr            (mem_waddr),
    .mem_wdata            (mem_wdata),
    .mem_wid              (mem_wid),
    .done                 (done),
    .halted               (halted)
  );

  // Record every memory handshake that the coming edge will complete
  always @(negedge aclk) begin
    if (!areset && mem_wvalid && mem_wready) begin
      log_addr.push_back(mem_waddr);
      log_data.push_back(mem_wdata);
      log_wid.push_back(mem_wid);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qa(input int i);
    return (i < log_addr.size()) ? log_addr[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] qd(input int i);
    return (i < log_data.size()) ? log_data[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] qw(input int i);
    return (i < log_wid.size()) ? 32'(log_wid[i]) : 32'hDEAD_BEEF;
  endfunction

  task automatic log_clear();
    log_addr.delete();
    log_data.delete();
    log_wid.delete();
  endtask

  task automatic drive_src();
    s_tvalid[0] = en[0] && (sent[0] < nbeats[0]);
    s_tlast[0]  = s_tvalid[0] && (sent[0] == last_at[0]);
    s_tdata0    = dbase[0] + 32'(sent[0]);
    s_tvalid[1] = en[1] && (sent[1] < nbeats[1]);
    s_tlast[1]  = s_tvalid[1] && (sent[1] == last_at[1]);
    s_tdata1    = dbase[1] + 32'(sent[1]);
  endtask

  // One clock: called and returns at posedge+1
  task automatic step();
    logic [1:0] acc;
    reg_wvalid = rw_pend;
    reg_waddr  = rw_addr;
    reg_wdata  = rw_data;
    @(negedge aclk);
    acc = s_tvalid & s_tready;
    @(posedge aclk);
    #1;
    reg_wvalid = 1'b0;
    rw_pend    = 1'b0;
    if (acc[0]) sent[0]++;
    if (acc[1]) sent[1]++;
    drive_src();
  endtask

  task automatic reg_write(input logic [31:0] a, input logic [31:0] d);
    rw_pend = 1'b1;
    rw_addr = a;
    rw_data = d;
    step();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic setup_src(input int c, input logic [31:0] db, input int nb, input int la);
    en[c]      = 1'b1;
    dbase[c]   = db;
    nbeats[c]  = nb;
    last_at[c] = la;
    sent[c]    = 0;
    drive_src();
  endtask

  task automatic wait_done(input int ch, input int budget, input string tag);
    int n;
    n = 0;
    while ((done[ch] !== 1'b1) && (n < budget)) begin
      step();
      n++;
    end
    chk(tag, 32'(done[ch]), 32'd1);
  endtask

  task automatic wait_wvalid(input int budget, input string tag);
    int n;
    n = 0;
    while ((mem_wvalid !== 1'b1) && (n < budget)) begin
      step();
      n++;
    end
    chk(tag, 32'(mem_wvalid), 32'd1);
  endtask

  initial begin
    int n;
    int cnt[2];
    int errs;
    int same;
    logic [31:0] last_a[2];
    logic [31:0] ea;
    logic        w;

    areset = 1'b1; reg_wvalid = 1'b0; reg_waddr = '0; reg_wdata = '0;
    s_tvalid = '0; s_tlast = '0; s_tdata0 = '0; s_tdata1 = '0; mem_wready = 1'b0;
    rw_pend = 1'b0; rw_addr = '0; rw_data = '0; en = '0;
    for (int c = 0; c < 2; c++) begin
      sent[c] = 0; nbeats[c] = 0; last_at[c] = -1; dbase[c] = '0;
    end

    // Reset values
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_tready", 32'(s_tready), 32'd0);
    chk("rst_wvalid", 32'(mem_wvalid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_halted", 32'(halted), 32'd3);
    chk("rst_waddr", mem_waddr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_wid", 32'(mem_wid), 32'd0);
    areset = 1'b0;
    @(posedge aclk);
    #1;

    // Basic 4-beat transfer on channel 0
    log_clear();
    mem_wready = 1'b1;
    setup_src(0, 32'd0, 4, 3);
    reg_write(B0 + 32'h30, 32'd1);
    reg_write(B0 + 32'h48, 32'h7600_0000);
    reg_write(B0 + 32'h58, 32'd16);
    wait_done(0, 50, "t1_done");
    run(3);
    chk("t1_count", 32'(log_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", qa(i), 32'h7600_0000 + 32'(4 * i));
      chk("t1_data", qd(i), 32'(i));
      chk("t1_wid", qw(i), 32'd0);
    end
    chk("t1_tready", 32'(s_tready[0]), 32'd0);
    chk("t1_halted", 32'(halted), 32'd2);
    chk("t1_done_vec", 32'(done), 32'd1);
    en[0] = 1'b0;
    drive_src();

    // Early tlast ends a 16-beat transfer after 3 beats
    reg_write(B0 + 32'h34, 32'h0000_1000);
    chk("t2_done_clr", 32'(done), 32'd0);
    log_clear();
    setup_src(0, 32'h100, 5, 2);
    reg_write(B0 + 32'h48, 32'h7600_1000);
    reg_write(B0 + 32'h58, 32'd64);
    run(40);
    chk("t2_count", 32'(log_addr.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_addr", qa(i), 32'h7600_1000 + 32'(4 * i));
      chk("t2_data", qd(i), 32'h100 + 32'(i));
    end
    chk("t2_accepted", 32'(sent[0]), 32'd3);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_tready", 32'(s_tready[0]), 32'd0);
    en[0] = 1'b0;
    drive_src();

    // Backpressure on channel 1
    log_clear();
    mem_wready = 1'b0;
    setup_src(1, 32'h200, 8, -1);
    reg_write(B1 + 32'h30, 32'd1);
    reg_write(B1 + 32'h48, 32'h7610_0000);
    reg_write(B1 + 32'h58, 32'd32);
    wait_wvalid(20, "t3_wvalid");
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t3_hold_valid", 32'(mem_wvalid), 32'd1);
      chk("t3_hold_addr", mem_waddr, 32'h7610_0000);
      chk("t3_hold_data", mem_wdata, 32'h200);
      chk("t3_hold_wid", 32'(mem_wid), 32'd1);
      chk("t3_hold_tready", 32'(s_tready[1]), 32'd0);
    end
    chk("t3_accepted", 32'(sent[1]), 32'd1);
    mem_wready = 1'b1;
    wait_done(1, 100, "t3_done");
    run(2);
    chk("t3_count", 32'(log_addr.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("t3_addr", qa(i), 32'h7610_0000 + 32'(4 * i));
      chk("t3_data", qd(i), 32'h200 + 32'(i));
      chk("t3_wid", qw(i), 32'd1);
    end
    en[1] = 1'b0;
    drive_src();

    // RS cleared after 2 of 8 beats
    reg_write(B0 + 32'h34, 32'h0000_1000);
    chk("t4_done0_clr", 32'(done), 32'd2);
    log_clear();
    setup_src(0, 32'h300, 8, -1);
    reg_write(B0 + 32'h48, 32'h7620_0000);
    reg_write(B0 + 32'h58, 32'd32);
    n = 0;
    while ((sent[0] < 2) && (n < 50)) begin
      step();
      n++;
    end
    chk("t4_two_beats", 32'(sent[0]), 32'd2);
    reg_write(B0 + 32'h30, 32'd0);
    run(20);
    chk("t4_halted", 32'(halted[0]), 32'd1);
    chk("t4_done", 32'(done[0]), 32'd0);
    chk("t4_tready", 32'(s_tready[0]), 32'd0);
    chk("t4_no_loss", 32'(log_addr.size()), 32'(sent[0]));
    chk("t4_at_most3", 32'(sent[0] <= 3), 32'd1);
    for (int i = 0; i < 2; i++) begin
      chk("t4_addr", qa(i), 32'h7620_0000 + 32'(4 * i));
      chk("t4_data", qd(i), 32'h300 + 32'(i));
    end
    reg_write(B1 + 32'h34, 32'h0000_1000);
    chk("t4_done1_clr", 32'(done), 32'd0);
    en[0] = 1'b0;
    drive_src();

    // Both channels streaming concurrently, 1024 beats each
    log_clear();
    mem_wready = 1'b1;
    setup_src(0, 32'd0, 1024, 1023);
    setup_src(1, 32'd0, 1024, 1023);
    reg_write(B0 + 32'h30, 32'd1);
    reg_write(B0 + 32'h48, 32'h7600_0000);
    reg_write(B1 + 32'h48, 32'h7610_0000);
    reg_write(B0 + 32'h58, 32'h0000_1000);
    reg_write(B1 + 32'h58, 32'h0000_1000);
    n = 0;
    while ((done !== 2'b11) && (n < 4000)) begin
      step();
      n++;
    end
    chk("t5_done", 32'(done), 32'd3);
    run(2);
    cnt[0] = 0; cnt[1] = 0; errs = 0; same = 0;
    last_a[0] = '0; last_a[1] = '0;
    for (int i = 0; i < log_addr.size(); i++) begin
      w  = log_wid[i];
      ea = (w ? 32'h7610_0000 : 32'h7600_0000) + 32'(4 * cnt[w]);
      if (log_addr[i] !== ea) errs++;
      if (log_data[i] !== 32'(cnt[w])) errs++;
      last_a[w] = log_addr[i];
      cnt[w]++;
      if ((i > 0) && (log_wid[i] == log_wid[i-1])) same++;
    end
    chk("t5_count0", 32'(cnt[0]), 32'd1024);
    chk("t5_count1", 32'(cnt[1]), 32'd1024);
    chk("t5_order_errs", 32'(errs), 32'd0);
    chk("t5_last0", last_a[0], 32'h7600_0FFC);
    chk("t5_last1", last_a[1], 32'h7610_0FFC);
    chk("t5_alternate", 32'(same <= 2), 32'd1);
    en = '0;
    drive_src();

    // Asynchronous reset with a write pending
    log_clear();
    mem_wready = 1'b0;
    setup_src(0, 32'h400, 16, -1);
    reg_write(B0 + 32'h48, 32'h7630_0000);
    reg_write(B0 + 32'h58, 32'd64);
    wait_wvalid(20, "t6_wvalid");
    chk("t6_pre_done", 32'(done), 32'd3);
    areset = 1'b1;
    #1;
    chk("t6_tready", 32'(s_tready), 32'd0);
    chk("t6_wvalid", 32'(mem_wvalid), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_halted", 32'(halted), 32'd3);
    chk("t6_waddr", mem_waddr, 32'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    en = '0;
    drive_src();
    log_clear();
    mem_wready = 1'b1;
    setup_src(0, 32'h500, 2, -1);
    reg_write(B0 + 32'h30, 32'd1);
    reg_write(B0 + 32'h48, 32'h7640_0000);
    reg_write(B0 + 32'h58, 32'd8);
    wait_done(0, 50, "t6_redo_done");
    run(2);
    chk("t6_count", 32'(log_addr.size()), 32'd2);
    for (int i = 0; i < 2; i++) begin
      chk("t6_addr", qa(i), 32'h7640_0000 + 32'(4 * i));
      chk("t6_data", qd(i), 32'h500 + 32'(i));
      chk("t6_wid", qw(i), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_sim_top.md
Name: dma_sim_top

Overview:
- Dual-channel stream-to-memory-mapped (S2MM) DMA write engine.
- Two independent 32-bit AXI4-Stream slave inputs are each programmed through a shared register-write port (DMACR, DA, LENGTH).
- Accepted beats are converted into word writes on one shared, round-robin-arbitrated memory write port.
- Sits between stream producers and the memory/interconnect model; replaces the two-AXI-DMA subsystem.

Parameters:
- DATA_WIDTH, 32: stream and memory data width; fixed at 32 (4 bytes per beat).
- ADDR_WIDTH, 32: register and memory address width.
- DMA1_BASE, 32'h41E0_0000: channel 0 register base.
- DMA2_BASE, 32'h41E1_0000: channel 1 register base.
- LEN_WIDTH, 26: byte-length counter width.

Ports:
- aclk  in  1  clock; all logic rises on posedge.
- areset  in  1  asynchronous, active-high reset.
- reg_wvalid  in  1  register write strobe; always accepted, single cycle.
- reg_waddr  in  ADDR_WIDTH  register byte address.
- reg_wdata  in  32  register write data.
- s_axis_s2mm_1_tdata  in  32  channel 0 stream data.
- s_axis_s2mm_1_tvalid  in  1  channel 0 stream valid.
- s_axis_s2mm_1_tlast  in  1  channel 0 end of packet.
- s_axis_s2mm_1_tready  out  1  channel 0 ready.
- s_axis_s2mm_2_tdata / _tvalid / _tlast / _tready: same as channel 0, for channel 1.
- mem_wvalid  out  1  memory write request.
- mem_wready  in  1  memory accepts the request.
- mem_waddr  out  ADDR_WIDTH  word-aligned byte address.
- mem_wdata  out  32  write data.
- mem_wid  out  1  source channel (0 = DMA1, 1 = DMA2).
- done  out  2  per-channel IOC flag (bit0 = channel 0); sticky.
- halted  out  2  per-channel halted status.

Behaviour:
- Register map, per channel, at base + offset:
  - 0x30 DMACR: bit0 = RS (run/stop).
  - 0x34 DMASR: write 1 to bit12 clears done.
  - 0x48 DA: destination address; bits[1:0] forced to 0.
  - 0x58 LENGTH: byte count in bits[LEN_WIDTH-1:0].
- Writes to unmapped addresses are ignored.
- Reset: all registers are 0. Outputs: tready = 0, mem_wvalid = 0, done = 0, halted = 2'b11, mem_waddr/wdata/wid = 0.
- Channel states are IDLE, BUSY and HALT.
  - HALT while RS = 0. When RS = 1: IDLE until LENGTH is written.
  - LENGTH write in IDLE with value ≥ 4 and RS = 1: load remaining = LENGTH[LEN_WIDTH-1:0] & ~3, load ptr = DA, enter BUSY the next cycle.
  - LENGTH = 0 is ignored. LENGTH writes while BUSY are ignored.
  - DA writes while BUSY are ignored for the current transfer.
- Each channel has a one-entry buffer.
  - tready = BUSY && remaining != 0 && buffer empty. tready is registered-free combinational of state.
  - A beat is accepted when tvalid && tready: buffer ← {ptr, tdata}, ptr += 4, remaining −= 4.
  - If remaining reaches 0 or tlast is accepted: stop accepting, wait for the buffer to drain, then set done, return to IDLE.
  - An early tlast ends the transfer; leftover length is discarded.
  - tlast is ignored otherwise. Surplus stream beats after completion stall (tready = 0).
- Arbiter:
  - When exactly one buffer is full, grant it.
  - When both are full, alternate, starting with channel 0 after reset. Priority flips after each completed grant.
  - mem_wvalid/addr/data/wid are held stable until mem_wready. The buffer frees on the handshake cycle, so a new beat may be accepted the next cycle.
  - Peak throughput is 1 beat per 2 cycles per channel, and 1 beat per cycle aggregate.
- RS cleared mid-transfer: tready drops the next cycle; the buffered beat still drains; enter HALT without setting done; remaining is discarded.
- RS cleared and a LENGTH write in the same cycle: the LENGTH write is ignored.
- Simultaneous accept on both channels is allowed: the buffers are independent.
- Asynchronous reset mid-operation aborts everything and returns to reset values immediately; any pending memory write is dropped.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.

Decomposition:
- Package dma_sim_pkg holds:
  - register offsets (DMACR 0x30, DMASR 0x34, DA 0x48, LENGTH 0x58);
  - the channel state enum {HALT, IDLE, BUSY};
  - bytes-per-beat = 4.
- Sub-module dma_s2mm_channel holds registers, the state machine, counters and the buffer. It is instantiated twice; the top holds register decode and the round-robin arbiter.

Test Plan:
- Program channel 0: DMACR = 1, DA = 0x7600_0000, LENGTH = 16. Stream data 0..3 with tlast on the 4th beat, mem_wready = 1 → writes (0x76000000, 0), (…04, 1), (…08, 2), (…0C, 3), all with wid 0; then done[0] = 1, tready = 0.
- Both channels run: DA 0x7600_0000 and 0x7610_0000, LENGTH 0x10_0000, continuous tvalid, tlast on data 0x3FFFF. Required: writes alternate wid 0/1, 262144 writes each, last addresses 0x760FFFFC and 0x761FFFFC, done = 2'b11.
- Backpressure: mem_wready low for 10 cycles during a transfer → outputs stay stable; tready stays 0 while the buffer is full; no data is lost or duplicated.
- Early tlast: LENGTH = 64, tlast on the 3rd beat → 3 writes, then done; a 4th beat is not accepted.
- RS cleared after 2 of 8 beats → at most 3 writes; halted = 1; done = 0. DMASR bit12 write-1-clear clears a previously set done.
- areset asserted mid-transfer → tready, mem_wvalid and done go to 0 and halted to 1 immediately. A re-programmed transfer then starts from the new DA.
